// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: sequences the FFT core (config, input framing, in-flight limit, output bin tagging)
// Ports:
//   clk, aresetn                     clock, asynchronous active-low reset
//   in_tvalid/in_tready/in_tdata     windowed sample stream from the Hamming window stage
//   fft_cfg_tdata/tvalid/tready      one-shot forward-transform config word
//   fft_in_tdata/tvalid/tready/tlast framed FFT input stream ({32'h0, sample})
//   fft_out_tvalid/fft_out_tlast     FFT output beat qualifiers
//   bin_index/bin_keep/bin_last      output bin tag, keep flag for bins 0..NFFT/2, last kept bin
//   frame_done                       one-cycle pulse after each output tlast beat
//   frames_in_flight                 frames accepted into the FFT but not yet fully output
//   err_tlast                        sticky output tlast/count mismatch
module fft_frame_scheduler #(
    parameter int          NFFT         = 512,
    parameter int          LOG2_NFFT    = 9,
    parameter logic [15:0] CFG_WORD     = 16'h0001,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic [31:0]          in_tdata,
    output logic [15:0]          fft_cfg_tdata,
    output logic                 fft_cfg_tvalid,
    input  logic                 fft_cfg_tready,
    output logic [63:0]          fft_in_tdata,
    output logic                 fft_in_tvalid,
    input  logic                 fft_in_tready,
    output logic                 fft_in_tlast,
    input  logic                 fft_out_tvalid,
    input  logic                 fft_out_tlast,
    output logic [LOG2_NFFT-1:0] bin_index,
    output logic                 bin_keep,
    output logic                 bin_last,
    output logic                 frame_done,
    output logic [1:0]           frames_in_flight,
    output logic                 err_tlast
);
    localparam logic [LOG2_NFFT-1:0] LAST_IDX = LOG2_NFFT'(NFFT - 1);
    localparam logic [LOG2_NFFT-1:0] HALF_IDX = LOG2_NFFT'(NFFT / 2);
    localparam logic [LOG2_NFFT-1:0] ONE      = LOG2_NFFT'(1);
    localparam logic [1:0]           MAX_F    = 2'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_CFG, S_LOAD, S_HOLD} state_t;

    state_t               state;
    logic [LOG2_NFFT-1:0] in_cnt;
    logic [LOG2_NFFT-1:0] out_cnt;
    logic                 accept;
    logic                 frame_accept;
    logic                 out_end;

    // single output register stage: a new sample may enter whenever the slot is empty or draining
    assign in_tready     = (state == S_LOAD) && (!fft_in_tvalid || fft_in_tready);
    assign accept        = in_tvalid && in_tready;
    assign frame_accept  = accept && (in_cnt == LAST_IDX);
    assign out_end       = fft_out_tvalid && fft_out_tlast;
    assign fft_cfg_tdata = CFG_WORD;
    assign bin_index     = out_cnt;
    assign bin_keep      = fft_out_tvalid && (out_cnt <= HALF_IDX);
    assign bin_last      = bin_keep && (out_cnt == HALF_IDX);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= S_CFG;
            in_cnt           <= '0;
            out_cnt          <= '0;
            fft_cfg_tvalid   <= 1'b0;
            fft_in_tdata     <= '0;
            fft_in_tvalid    <= 1'b0;
            fft_in_tlast     <= 1'b0;
            frame_done       <= 1'b0;
            frames_in_flight <= 2'd0;
            err_tlast        <= 1'b0;
        end else begin
            frame_done <= out_end;
            if (fft_out_tvalid)
                out_cnt <= fft_out_tlast ? '0 : out_cnt + ONE;
            if (fft_out_tvalid && (fft_out_tlast != (out_cnt == LAST_IDX)))
                err_tlast <= 1'b1;
            if (accept) begin
                fft_in_tdata  <= {32'h0, in_tdata};
                fft_in_tvalid <= 1'b1;
                fft_in_tlast  <= (in_cnt == LAST_IDX);
                in_cnt        <= in_cnt + ONE;
            end else if (fft_in_tready) begin
                fft_in_tvalid <= 1'b0;
                fft_in_tlast  <= 1'b0;
            end
            // a frame entering and a frame leaving in the same cycle cancel out
            if (frame_accept && !out_end)
                frames_in_flight <= frames_in_flight + 2'd1;
            else if (out_end && !frame_accept) begin
                if (frames_in_flight == 2'd0)
                    err_tlast <= 1'b1;
                else
                    frames_in_flight <= frames_in_flight - 2'd1;
            end
            case (state)
                S_CFG: begin
                    if (fft_cfg_tvalid && fft_cfg_tready) begin
                        fft_cfg_tvalid <= 1'b0;
                        state          <= S_LOAD;
                    end else
                        fft_cfg_tvalid <= 1'b1;
                end
                S_LOAD: begin
                    if (frame_accept && !out_end && (frames_in_flight + 2'd1 == MAX_F))
                        state <= S_HOLD;
                end
                S_HOLD: begin
                    if (frames_in_flight < MAX_F)
                        state <= S_LOAD;
                end
                default: state <= S_CFG;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: randomized scoreboard bench for fft_frame_scheduler
module tb_fft_frame_scheduler;
    localparam int NFFT = 512;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [31:0] in_tdata = '0;
    logic [15:0] fft_cfg_tdata;
    logic        fft_cfg_tvalid;
    logic        fft_cfg_tready = 1'b0;
    logic [63:0] fft_in_tdata;
    logic        fft_in_tvalid;
    logic        fft_in_tready = 1'b1;
    logic        fft_in_tlast;
    logic        fft_out_tvalid = 1'b0;
    logic        fft_out_tlast = 1'b0;
    logic [8:0]  bin_index;
    logic        bin_keep;
    logic        bin_last;
    logic        frame_done;
    logic [1:0]  frames_in_flight;
    logic        err_tlast;

    fft_frame_scheduler #(
        .NFFT(NFFT), .LOG2_NFFT(9), .CFG_WORD(16'h0001), .MAX_INFLIGHT(2)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready),
        .fft_in_tdata(fft_in_tdata), .fft_in_tvalid(fft_in_tvalid), .fft_in_tready(fft_in_tready),
        .fft_in_tlast(fft_in_tlast),
        .fft_out_tvalid(fft_out_tvalid), .fft_out_tlast(fft_out_tlast),
        .bin_index(bin_index), .bin_keep(bin_keep), .bin_last(bin_last),
        .frame_done(frame_done), .frames_in_flight(frames_in_flight), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          seq = 0;
    logic [32:0] exp_q[$];
    logic [10:0] bin_q[$];
    logic        prev_end = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops expected beats whenever the DUT presents one
    initial begin : mon
        logic [32:0] e;
        logic [10:0] b;
        forever begin
            @(negedge clk);
            if (!aresetn)
                prev_end = 1'b0;
            else begin
                if (fft_in_tvalid && fft_in_tready) begin
                    if (exp_q.size() == 0)
                        chk("fft_in_extra_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("fft_in_tdata", fft_in_tdata, {32'h0, e[32:1]});
                        chk("fft_in_tlast", fft_in_tlast, e[0]);
                    end
                end
                if (fft_out_tvalid) begin
                    if (bin_q.size() == 0)
                        chk("bin_extra_beat", 1, 0);
                    else begin
                        b = bin_q.pop_front();
                        chk("bin_index", bin_index, b[8:0]);
                        chk("bin_keep", bin_keep, b[10]);
                        chk("bin_last", bin_last, b[9]);
                    end
                end
                chk("frame_done", frame_done, prev_end);
                prev_end = fft_out_tvalid && fft_out_tlast;
            end
        end
    end

    task automatic cfg_phase(input int hold);
        int hi = 0;
        int bad = 0;
        fft_cfg_tready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fft_cfg_tvalid) begin
                hi++;
                if (fft_cfg_tdata !== 16'h0001 || in_tready !== 1'b0) bad++;
                if (hi == hold) fft_cfg_tready = 1'b1;
            end else if (hi > 0)
                break;
        end
        chk("cfg_valid_cycles", hi, hold);
        chk("cfg_phase_bad", bad, 0);
        chk("in_tready_after_cfg", in_tready, 1);
        fft_cfg_tready = 1'b0;
    endtask

    task automatic feed(input int n, input bit rnd, output int cyc);
        int got = 0;
        cyc = 0;
        while (got < n && cyc < 20000) begin
            @(posedge clk); #1;
            in_tvalid     = rnd ? ($urandom_range(3) != 0) : 1'b1;
            in_tdata      = $urandom;
            fft_in_tready = rnd ? ($urandom_range(1) == 1) : 1'b1;
            @(negedge clk);
            if (in_tvalid && in_tready) begin
                exp_q.push_back({in_tdata, (seq % NFFT) == NFFT - 1});
                seq++;
                got++;
            end
            cyc++;
        end
        if (got < n) chk("feed_timeout", got, n);
        @(posedge clk); #1;
        in_tvalid     = 1'b0;
        fft_in_tready = 1'b1;
    endtask

    task automatic out_frame(input int last_at, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i <= last_at && cyc < 5000) begin
            @(posedge clk); #1;
            fft_out_tvalid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            fft_out_tlast  = fft_out_tvalid && (i == last_at);
            if (fft_out_tvalid) begin
                bin_q.push_back({i <= NFFT / 2, i == NFFT / 2, 9'(i)});
                i++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        fft_out_tvalid = 1'b0;
        fft_out_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int acc;
        int w;
        #22;
        chk("rst_cfg_tvalid", fft_cfg_tvalid, 0);
        chk("rst_in_tvalid", fft_in_tvalid, 0);
        chk("rst_in_tlast", fft_in_tlast, 0);
        chk("rst_in_tdata", fft_in_tdata, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err_tlast, 0);
        chk("rst_fif", frames_in_flight, 0);
        chk("rst_in_tready", in_tready, 0);
        @(negedge clk);
        aresetn = 1'b1;
        cfg_phase(6);
        @(negedge clk);
        chk("cfg_tvalid_after", fft_cfg_tvalid, 0);

        feed(512, 1'b0, cyc);
        chk("frame1_cycles", cyc, 512);
        chk("fif_frame1", frames_in_flight, 1);
        drain("drain_frame1");
        out_frame(511, 1'b0);
        @(negedge clk);
        chk("fif_after_out1", frames_in_flight, 0);

        feed(1024, 1'b1, cyc);
        drain("drain_random");
        chk("fif_two", frames_in_flight, 2);
        in_tvalid = 1'b1;
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (in_tready) acc++;
        end
        in_tvalid = 1'b0;
        chk("hold_in_tready", acc, 0);
        out_frame(511, 1'b1);
        @(negedge clk);
        chk("fif_after_hold_out", frames_in_flight, 1);
        w = 0;
        while (!in_tready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("in_tready_reassert", in_tready, 1);
        feed(512, 1'b0, cyc);
        drain("drain_frame3");
        chk("fif_frame3", frames_in_flight, 2);
        chk("err_clean", err_tlast, 0);

        out_frame(511, 1'b0);
        out_frame(300, 1'b0);
        @(negedge clk);
        chk("err_short_frame", err_tlast, 1);
        chk("fif_after_short", frames_in_flight, 0);
        out_frame(511, 1'b0);
        @(negedge clk);
        chk("err_sticky", err_tlast, 1);
        chk("fif_spurious", frames_in_flight, 0);

        feed(100, 1'b0, cyc);
        @(posedge clk); #3;
        aresetn = 1'b0;
        #1;
        chk("arst_in_tdata", fft_in_tdata, 0);
        chk("arst_err", err_tlast, 0);
        chk("arst_in_tready", in_tready, 0);
        chk("arst_fif", frames_in_flight, 0);
        exp_q.delete();
        seq = 0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        cfg_phase(1);
        feed(512, 1'b0, cyc);
        chk("fif_restart", frames_in_flight, 1);
        drain("drain_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
